// File: rtl/hour_display_ctrl.sv
// rtl/hour_display_ctrl.sv - 12-hour BCD decode, AM/PM wrap tracking and 2-digit multiplexed 7-seg drive
module hour_display_ctrl #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_count,
    input  logic       i_control,
    output logic [3:0] o_hour_tens,
    output logic [3:0] o_hour_ones,
    output logic       o_pm,
    output logic       o_wrap,
    output logic       o_err,
    output logic [6:0] o_seg_n,
    output logic [1:0] o_an_n
);
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_MASK  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    logic [3:0]    r_cur;
    logic          r_prev_valid;
    logic          r_dir;
    logic [RW-1:0] r_refresh;
    logic          r_sel;

    logic       w_legal;
    logic       w_up_wrap;
    logic       w_down_wrap;
    logic       w_wrap;
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    logic [3:0] w_digit;
    logic       w_blank;
    logic [6:0] w_seg;

    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 7'b0111111;
            4'd1:    f_seg7 = 7'b0000110;
            4'd2:    f_seg7 = 7'b1011011;
            4'd3:    f_seg7 = 7'b1001111;
            4'd4:    f_seg7 = 7'b1100110;
            4'd5:    f_seg7 = 7'b1101101;
            4'd6:    f_seg7 = 7'b1111101;
            4'd7:    f_seg7 = 7'b0000111;
            4'd8:    f_seg7 = 7'b1111111;
            4'd9:    f_seg7 = 7'b1101111;
            default: f_seg7 = 7'b0000000;
        endcase
    endfunction

    // r_cur is the previous sample relative to i_count, so wraps line up with the hour update
    always_comb begin
        w_legal     = (i_count < 4'd12);
        w_up_wrap   = r_prev_valid && (r_cur == 4'd11) && (i_count == 4'd0);
        w_down_wrap = r_prev_valid && (r_cur == 4'd0) && (i_count == 4'd11);
        // Direction is informational: both wraps are accepted whichever way the counter runs
        w_wrap      = r_dir ? (w_down_wrap | w_up_wrap) : (w_up_wrap | w_down_wrap);
        w_tens      = 4'd0;
        w_ones      = i_count;
        if (i_count == 4'd0) begin
            w_tens = 4'd1;
            w_ones = 4'd2;
        end else if (i_count >= 4'd10) begin
            w_tens = 4'd1;
            w_ones = i_count - 4'd10;
        end
    end

    always_comb begin
        w_digit = r_sel ? o_hour_tens : o_hour_ones;
        w_blank = r_sel && (o_hour_tens == 4'd0);
        w_seg   = 7'b0000000;
        if (o_err)
            w_seg = SEG_DASH;
        else if (!w_blank)
            w_seg = f_seg7(w_digit);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cur        <= 4'd0;
            r_prev_valid <= 1'b0;
            r_dir        <= 1'b0;
            o_hour_tens  <= 4'd1;
            o_hour_ones  <= 4'd2;
            o_pm         <= 1'b0;
            o_wrap       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            r_cur        <= i_count;
            r_prev_valid <= 1'b1;
            r_dir        <= i_control;
            o_err        <= !w_legal;
            o_wrap       <= w_wrap;
            if (w_wrap)
                o_pm <= !o_pm;
            if (w_legal) begin
                o_hour_tens <= w_tens;
                o_hour_ones <= w_ones;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_refresh <= '0;
            r_sel     <= 1'b0;
            o_seg_n   <= SEG_MASK ^ 7'b0000000;
            o_an_n    <= AN_MASK ^ 2'b00;
        end else begin
            if (r_refresh == REFRESH_LAST) begin
                r_refresh <= '0;
                r_sel     <= !r_sel;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            o_seg_n <= SEG_MASK ^ w_seg;
            o_an_n  <= AN_MASK ^ (r_sel ? 2'b10 : 2'b01);
        end
    end
endmodule

// File: tb/tb_hour_display_ctrl.sv
// tb/tb_hour_display_ctrl.sv - directed self-checking bench for hour_display_ctrl
module tb_hour_display_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] count = 4'd0;
    logic       control = 1'b0;
    logic [3:0] hour_tens;
    logic [3:0] hour_ones;
    logic       pm;
    logic       wrap;
    logic       err;
    logic [6:0] seg_n;
    logic [1:0] an_n;

    int checks = 0;
    int failures = 0;

    hour_display_ctrl #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_count     (count),
        .i_control   (control),
        .o_hour_tens (hour_tens),
        .o_hour_ones (hour_ones),
        .o_pm        (pm),
        .o_wrap      (wrap),
        .o_err       (err),
        .o_seg_n     (seg_n),
        .o_an_n      (an_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_hour(input int v);
        if (v == 0) return 8'h12;
        if (v < 10) return 8'(v);
        if (v == 10) return 8'h10;
        return 8'h11;
    endfunction

    initial begin
        logic [1:0] exp_an;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_hour", {hour_tens, hour_ones}, 8'h12);
        check("rst_pm", pm, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_an", an_n, 2'b11);
        check("rst_seg", seg_n, 7'h7F);

        reset = 1'b0;
        count = 4'd0;
        tick();
        check("t1_hour", {hour_tens, hour_ones}, 8'h12);
        check("t1_wrap", wrap, 1'b0);

        // Count up 0..11 then wrap to 0
        for (int v = 0; v < 12; v++) begin
            count = 4'(v);
            tick();
            check($sformatf("t2_hour_%0d", v), {hour_tens, hour_ones}, exp_hour(v));
            check($sformatf("t2_nowrap_%0d", v), wrap, 1'b0);
        end
        check("t2_pm_before", pm, 1'b0);
        count = 4'd0;
        tick();
        check("t2_wrap_hour", {hour_tens, hour_ones}, 8'h12);
        check("t2_wrap", wrap, 1'b1);
        check("t2_pm", pm, 1'b1);
        tick();
        check("t2_wrap_pulse", wrap, 1'b0);
        check("t2_pm_hold", pm, 1'b1);

        // Down wrap 0 -> 11
        control = 1'b1;
        tick();
        check("t3_hold_wrap", wrap, 1'b0);
        count = 4'd11;
        tick();
        check("t3_wrap", wrap, 1'b1);
        check("t3_pm", pm, 1'b0);
        check("t3_hour", {hour_tens, hour_ones}, 8'h11);
        tick();
        check("t3_wrap_pulse", wrap, 1'b0);

        // Illegal values hold the hour, 12 -> 11 is not a wrap
        count = 4'd3;
        tick();
        check("t4_hour3", {hour_tens, hour_ones}, 8'h03);
        check("t4_err0", err, 1'b0);
        for (int v = 15; v >= 12; v--) begin
            count = 4'(v);
            tick();
            check($sformatf("t4_err_%0d", v), err, 1'b1);
            check($sformatf("t4_hold_%0d", v), {hour_tens, hour_ones}, 8'h03);
            check($sformatf("t4_nowrap_%0d", v), wrap, 1'b0);
        end
        check("t4_err_seg", seg_n, 7'b0111111);
        count = 4'd11;
        tick();
        check("t4_err_clr", err, 1'b0);
        check("t4_hour11", {hour_tens, hour_ones}, 8'h11);
        check("t4_nowrap_exit", wrap, 1'b0);
        check("t4_pm", pm, 1'b0);

        // Display multiplexing with REFRESH_DIV=4
        control = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count = 4'd10;
        for (int k = 1; k <= 20; k++) begin
            if (k == 13) count = 4'd5;
            tick();
            exp_an = (((k - 1) / 4) % 2 == 1) ? 2'b01 : 2'b10;
            check($sformatf("t5_an_%0d", k), an_n, exp_an);
            if (k >= 2 && k <= 12)
                check($sformatf("t5_seg10_%0d", k), seg_n,
                      (exp_an == 2'b01) ? 7'b1111001 : 7'b1000000);
            if (k >= 14)
                check($sformatf("t5_seg5_%0d", k), seg_n,
                      (exp_an == 2'b01) ? 7'h7F : 7'b0010010);
        end

        // Reset on a wrap cycle
        count = 4'd11;
        tick();
        count = 4'd0;
        tick();
        check("t6_pre_wrap", wrap, 1'b1);
        check("t6_pre_pm", pm, 1'b1);
        count = 4'd11;
        tick();
        count = 4'd0;
        reset = 1'b1;
        tick();
        check("t6_rst_pm", pm, 1'b0);
        check("t6_rst_wrap", wrap, 1'b0);
        check("t6_rst_hour", {hour_tens, hour_ones}, 8'h12);
        check("t6_rst_an", an_n, 2'b11);
        reset = 1'b0;
        count = 4'd11;
        tick();
        check("t6_first_nowrap", wrap, 1'b0);
        check("t6_first_pm", pm, 1'b0);
        check("t6_first_hour", {hour_tens, hour_ones}, 8'h11);
        count = 4'd0;
        tick();
        check("t6_next_wrap", wrap, 1'b1);
        check("t6_next_pm", pm, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
